mshr_tracker: RTL

MSHR_TRACKER -- requirements
Module: mshr_tracker

---
 rtl/mshr_tracker.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mshr_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mshr_tracker : miss-status holding registers with per-entry latency countdown
// Rev 1.0
// ============================================================================
module mshr_tracker #(
  parameter int NUM_ENTRIES = 4,
  parameter int IDX_W       = 2
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        miss_valid,
  input  logic [26:0] miss_addr,
  input  logic [4:0]  miss_latency,
  input  logic [2:0]  miss_warp_ID,
  input  logic [1:0]  miss_scb_ID,
  input  logic [4:0]  miss_reg_addr,
  input  logic        miss_is_write,
  output logic        mshr_full,
  output logic        mshr_neg_feedback_valid,
  output logic [26:0] mshr_neg_feedback_addr,
  output logic        replay_valid,
  output logic [2:0]  replay_warp_ID,
  output logic [1:0]  replay_scb_ID,
  output logic [4:0]  replay_reg_addr,
  output logic        replay_is_write,
  output logic        overflow_err
);

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [26:0]            addr_q  [NUM_ENTRIES];
  logic [26:0]            addr_d  [NUM_ENTRIES];
  logic [2:0]             warp_q  [NUM_ENTRIES];
  logic [2:0]             warp_d  [NUM_ENTRIES];
  logic [1:0]             scb_q   [NUM_ENTRIES];
  logic [1:0]             scb_d   [NUM_ENTRIES];
  logic [4:0]             reg_q   [NUM_ENTRIES];
  logic [4:0]             reg_d   [NUM_ENTRIES];
  logic                   wr_q    [NUM_ENTRIES];
  logic                   wr_d    [NUM_ENTRIES];
  logic [4:0]             count_q [NUM_ENTRIES];
  logic [4:0]             count_d [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] done;
  logic [IDX_W-1:0]       alloc_idx;
  logic [IDX_W-1:0]       retire_idx;
  logic                   retire_en;
  logic                   alloc_en;
  logic [4:0]             eff_lat;

  logic                   pulse_q, pulse_d;
  logic [26:0]            out_addr_q, out_addr_d;
  logic [2:0]             out_warp_q, out_warp_d;
  logic [1:0]             out_scb_q, out_scb_d;
  logic [4:0]             out_reg_q, out_reg_d;
  logic                   out_wr_q, out_wr_d;
  logic                   ovf_q, ovf_d;

  generate
    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_done
      assign done[g] = valid_q[g] && (count_q[g] == 5'd0);
    end
  endgenerate

  assign mshr_full = &valid_q;
  assign alloc_en  = miss_valid && !mshr_full;
  // A zero latency would be done on its own allocation edge; clamp to one.
  assign eff_lat   = (miss_latency == 5'd0) ? 5'd1 : miss_latency;

  // Descending scan so the lowest matching index wins; both searches use
  // pre-edge state, so a retiring entry is never reallocated on that edge.
  always_comb begin
    alloc_idx  = '0;
    retire_idx = '0;
    retire_en  = 1'b0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        alloc_idx = IDX_W'(i);
      end
      if (done[i]) begin
        retire_idx = IDX_W'(i);
        retire_en  = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    warp_d  = warp_q;
    scb_d   = scb_q;
    reg_d   = reg_q;
    wr_d    = wr_q;
    count_d = count_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i] && (count_q[i] != 5'd0)) begin
        count_d[i] = count_q[i] - 5'd1;
      end
      if (retire_en && (retire_idx == IDX_W'(i))) begin
        valid_d[i] = 1'b0;
      end
      if (alloc_en && (alloc_idx == IDX_W'(i))) begin
        valid_d[i] = 1'b1;
        addr_d[i]  = miss_addr;
        warp_d[i]  = miss_warp_ID;
        scb_d[i]   = miss_scb_ID;
        reg_d[i]   = miss_reg_addr;
        wr_d[i]    = miss_is_write;
        count_d[i] = eff_lat;
      end
    end
  end

  always_comb begin
    pulse_d    = retire_en;
    out_addr_d = out_addr_q;
    out_warp_d = out_warp_q;
    out_scb_d  = out_scb_q;
    out_reg_d  = out_reg_q;
    out_wr_d   = out_wr_q;
    if (retire_en) begin
      out_addr_d = addr_q[retire_idx];
      out_warp_d = warp_q[retire_idx];
      out_scb_d  = scb_q[retire_idx];
      out_reg_d  = reg_q[retire_idx];
      out_wr_d   = wr_q[retire_idx];
    end
    ovf_d = ovf_q | (miss_valid & mshr_full);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        addr_q[i]  <= '0;
        warp_q[i]  <= '0;
        scb_q[i]   <= '0;
        reg_q[i]   <= '0;
        wr_q[i]    <= 1'b0;
        count_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      warp_q  <= warp_d;
      scb_q   <= scb_d;
      reg_q   <= reg_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      pulse_q    <= 1'b0;
      out_addr_q <= '0;
      out_warp_q <= '0;
      out_scb_q  <= '0;
      out_reg_q  <= '0;
      out_wr_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      pulse_q    <= pulse_d;
      out_addr_q <= out_addr_d;
      out_warp_q <= out_warp_d;
      out_scb_q  <= out_scb_d;
      out_reg_q  <= out_reg_d;
      out_wr_q   <= out_wr_d;
      ovf_q      <= ovf_d;
    end
  end

  assign mshr_neg_feedback_valid = pulse_q;
  assign mshr_neg_feedback_addr  = out_addr_q;
  assign replay_valid            = pulse_q;
  assign replay_warp_ID          = out_warp_q;
  assign replay_scb_ID           = out_scb_q;
  assign replay_reg_addr         = out_reg_q;
  assign replay_is_write         = out_wr_q;
  assign overflow_err            = ovf_q;

endmodule
`default_nettype wire
